// File: rtl/gpio_pkg.sv
// Shared register indices, reset constants and elaboration helpers for gpio_irq.
package gpio_pkg;

    localparam logic [2:0] REG_OUT      = 3'd0;
    localparam logic [2:0] REG_TRIS     = 3'd1;
    localparam logic [2:0] REG_IN       = 3'd2;
    localparam logic [2:0] REG_OUTSET   = 3'd3;
    localparam logic [2:0] REG_OUTCLR   = 3'd4;
    localparam logic [2:0] REG_RISE_EN  = 3'd5;
    localparam logic [2:0] REG_FALL_EN  = 3'd6;
    localparam logic [2:0] REG_IRQ_STAT = 3'd7;

    localparam logic [31:0] TRIS_RST = 32'hFFFF_FFFF;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// 8-bit CPU register bus used to reach the gpio_irq register file.
interface gpio_irq_if;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       wr_en;
    logic       rd_en;

    modport master (output addr, output din, output wr_en, output rd_en, input dout);
    modport slave  (input addr, input din, input wr_en, input rd_en, output dout);
endinterface

// File: rtl/gpio_debounce.sv
// Per-pin stability filter: a pin only changes once it has held its new value for DB_CYCLES cycles.
module gpio_debounce #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] filt_o
);

    logic [7:0]       cnt_q [WIDTH];
    logic [7:0]       cnt_d [WIDTH];
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_d;

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (d_i[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == 8'(DB_CYCLES - 1)) begin
                filt_d[i] = d_i[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/gpio_irq.sv
// Byte-lane GPIO with atomic set/clear, synchronised inputs and edge interrupts.
// Optional input debounce when GPIO_DEBOUNCE_EN is defined.
module gpio_irq
    import gpio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_LSB  = 0,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    gpio_irq_if.slave        bus,
    input  logic [WIDTH-1:0] port_i,
    output logic [WIDTH-1:0] port_o,
    output logic [WIDTH-1:0] port_t,
    output logic             irq
);

    localparam int NBYTES = WIDTH / 8;
    localparam int BSEL_W = clog2(NBYTES);
    localparam int OFF_W  = 3 + BSEL_W;
    localparam int BS_W   = (BSEL_W > 0) ? BSEL_W : 1;

    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
        $error("gpio_irq: WIDTH must be 8, 16 or 32");
    end
    if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_db
        $error("gpio_irq: DB_CYCLES must be in 2..255");
    end

    logic [OFF_W-1:0] offset;
    logic [2:0]       reg_sel;
    logic [BS_W-1:0]  byte_sel;
    logic             unused_addr;

    assign offset      = bus.addr[ADDR_LSB +: OFF_W];
    assign reg_sel     = offset[OFF_W-1 -: 3];
    assign unused_addr = ^bus.addr;

    if (BSEL_W > 0) begin : g_bsel
        assign byte_sel = offset[BS_W-1:0];
    end else begin : g_no_bsel
        assign byte_sel = '0;
    end

    logic [WIDTH-1:0] out_q, out_d, tris_q, tris_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [7:0]       dout_q, dout_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] filt;

`ifdef GPIO_DEBOUNCE_EN
    gpio_debounce #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (sync2_q),
        .filt_o  (filt)
    );
`else
    assign filt = sync2_q;
`endif

    logic [WIDTH-1:0] lane_mask, wdata, wbits, stat_clr, evt, rd_word;

    assign lane_mask = WIDTH'(8'hFF) << (8 * byte_sel);
    assign wdata     = {NBYTES{bus.din}};
    assign wbits     = wdata & lane_mask;
    assign evt       = (filt & ~prev_q & rise_en_q) | (~filt & prev_q & fall_en_q);

    always_comb begin
        out_d     = out_q;
        tris_d    = tris_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        stat_clr  = '0;
        dout_d    = dout_q;
        rd_word   = '0;

        if (bus.wr_en) begin
            case (reg_sel)
                REG_OUT:      out_d     = (out_q & ~lane_mask) | wbits;
                REG_TRIS:     tris_d    = (tris_q & ~lane_mask) | wbits;
                REG_OUTSET:   out_d     = out_q | wbits;
                REG_OUTCLR:   out_d     = out_q & ~wbits;
                REG_RISE_EN:  rise_en_d = (rise_en_q & ~lane_mask) | wbits;
                REG_FALL_EN:  fall_en_d = (fall_en_q & ~lane_mask) | wbits;
                REG_IRQ_STAT: stat_clr  = wbits;
                default:      ;
            endcase
        end

        // A fresh edge event overrides a simultaneous W1C on the same bit.
        stat_d = (stat_q & ~stat_clr) | evt;

        case (reg_sel)
            REG_OUT:      rd_word = out_q;
            REG_TRIS:     rd_word = tris_q;
            REG_IN:       rd_word = filt;
            REG_RISE_EN:  rd_word = rise_en_q;
            REG_FALL_EN:  rd_word = fall_en_q;
            REG_IRQ_STAT: rd_word = stat_q;
            default:      rd_word = '0;
        endcase

        if (bus.rd_en && !bus.wr_en) dout_d = 8'(rd_word >> (8 * byte_sel));

        irq_d   = |stat_q;
        sync1_d = port_i;
        sync2_d = sync1_q;
        prev_d  = filt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= '0;
            tris_q    <= TRIS_RST[WIDTH-1:0];
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            dout_q    <= 8'h00;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            tris_q    <= tris_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            dout_q    <= dout_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.dout = dout_q;
    assign port_o   = out_q;
    assign port_t   = tris_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Scoreboard bench for gpio_irq at WIDTH=16; expected read data is queued when the read strobe is driven.
module tb_gpio_irq;

    localparam int WIDTH = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DBL = 4;
`else
    localparam int DBL = 0;
`endif
    localparam int LAT = 2 + DBL;

    localparam int R_OUT = 0, R_TRIS = 1, R_IN = 2, R_SET = 3, R_CLR = 4;
    localparam int R_RISE = 5, R_FALL = 6, R_STAT = 7;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] port_i = '0;
    logic [WIDTH-1:0] port_o, port_t;
    logic             irq;

    gpio_irq_if bus ();

    gpio_irq #(.WIDTH(WIDTH), .ADDR_LSB(0), .DB_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .port_i  (port_i),
        .port_o  (port_o),
        .port_t  (port_t),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] sb [$];
    logic [7:0] exp8;

    function automatic logic [7:0] ra(input int r, input int b);
        return 8'(r * 2 + b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.addr = a; bus.din = d; bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        bus.addr = a; bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        vectors++;
        if (port_o !== 16'h0000 || port_t !== 16'hFFFF || irq !== 1'b0 || bus.dout !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_defaults: got o=%h t=%h irq=%b dout=%h required o=0000 t=ffff irq=0 dout=00",
                     port_o, port_t, irq, bus.dout);
        end
        reset_n = 1'b1;
        tick();
        wr(ra(R_OUT, 0), 8'hA5);
        vectors++;
        if (port_o !== 16'h00A5) begin
            miscompares++;
            $display("FAIL pre_reset_out: got %h required 00a5", port_o);
        end
        sb.push_back(8'hA5);
        rd(ra(R_OUT, 0));
        exp8 = sb.pop_front();
        vectors++;
        if (bus.dout !== exp8) begin
            miscompares++;
            $display("FAIL pre_reset_read: got %h required %h", bus.dout, exp8);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (port_o !== 16'h0000 || port_t !== 16'hFFFF || irq !== 1'b0 || bus.dout !== 8'h00) begin
            miscompares++;
            $display("FAIL midcycle_reset: got o=%h t=%h irq=%b dout=%h required o=0000 t=ffff irq=0 dout=00",
                     port_o, port_t, irq, bus.dout);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_byte_lanes();
        wr(ra(R_OUT, 1), 8'h3C);
        vectors++;
        if (port_o !== 16'h3C00) begin
            miscompares++;
            $display("FAIL lane_out_write: got %h required 3c00", port_o);
        end
        wr(ra(R_TRIS, 0), 8'h0F);
        vectors++;
        if (port_t !== 16'hFF0F) begin
            miscompares++;
            $display("FAIL lane_tris_write: got %h required ff0f", port_t);
        end
        sb.push_back(8'h3C);
        rd(ra(R_OUT, 1));
        exp8 = sb.pop_front();
        vectors++;
        if (bus.dout !== exp8) begin
            miscompares++;
            $display("FAIL lane_read_b1: got %h required %h", bus.dout, exp8);
        end
        sb.push_back(8'h00);
        rd(ra(R_OUT, 0));
        exp8 = sb.pop_front();
        vectors++;
        if (bus.dout !== exp8) begin
            miscompares++;
            $display("FAIL lane_read_b0: got %h required %h", bus.dout, exp8);
        end
    endtask

    task automatic test_outset_clr();
        wr(ra(R_OUT, 0), 8'hF0);
        wr(ra(R_SET, 0), 8'h0F);
        vectors++;
        if (port_o !== 16'h3CFF) begin
            miscompares++;
            $display("FAIL outset: got %h required 3cff", port_o);
        end
        wr(ra(R_CLR, 0), 8'h81);
        vectors++;
        if (port_o !== 16'h3C7E) begin
            miscompares++;
            $display("FAIL outclr: got %h required 3c7e", port_o);
        end
        wr(ra(R_SET, 1), 8'h80);
        vectors++;
        if (port_o !== 16'hBC7E) begin
            miscompares++;
            $display("FAIL outset_b1: got %h required bc7e", port_o);
        end
        sb.push_back(8'h00);
        sb.push_back(8'hBC);
        sb.push_back(8'h7E);
        foreach (sb[i]) begin end
        for (int i = 0; i < 3; i++) begin
            bus.addr = (i == 0) ? ra(R_SET, 0) : (i == 1) ? ra(R_OUT, 1) : ra(R_OUT, 0);
            bus.rd_en = 1'b1;
            tick();
            exp8 = sb.pop_front();
            vectors++;
            if (bus.dout !== exp8) begin
                miscompares++;
                $display("FAIL back_to_back_read%0d: got %h required %h", i, bus.dout, exp8);
            end
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_rw_priority();
        bus.addr = ra(R_TRIS, 1); bus.din = 8'h12;
        bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        tick();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        vectors++;
        if (bus.dout !== 8'h7E || port_t !== 16'h120F) begin
            miscompares++;
            $display("FAIL wr_over_rd: got dout=%h t=%h required dout=7e t=120f", bus.dout, port_t);
        end
        tick();
        vectors++;
        if (bus.dout !== 8'h7E) begin
            miscompares++;
            $display("FAIL dout_hold: got %h required 7e", bus.dout);
        end
    endtask

    task automatic test_in_latency();
        port_i[15:8] = 8'h5A;
        for (int k = 1; k <= LAT + 1; k++) begin
            if (k >= LAT) begin
                bus.addr = ra(R_IN, 1); bus.rd_en = 1'b1;
                sb.push_back((k == LAT) ? 8'h00 : 8'h5A);
            end
            tick();
            bus.rd_en = 1'b0;
            if (k >= LAT) begin
                exp8 = sb.pop_front();
                vectors++;
                if (bus.dout !== exp8) begin
                    miscompares++;
                    $display("FAIL in_latency_k%0d: got %h required %h", k, bus.dout, exp8);
                end
            end
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL in_no_irq: got %b required 0", irq);
        end
    endtask

    task automatic test_rise_irq();
        logic exp_irq;
        wr(ra(R_RISE, 0), 8'h01);
        port_i[0] = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            if (k >= LAT + 1) begin
                bus.addr = ra(R_STAT, 0); bus.rd_en = 1'b1;
                sb.push_back((k >= LAT + 2) ? 8'h01 : 8'h00);
            end
            tick();
            bus.rd_en = 1'b0;
            exp_irq = (k >= LAT + 2);
            vectors++;
            if (irq !== exp_irq) begin
                miscompares++;
                $display("FAIL rise_irq_k%0d: got %b required %b", k, irq, exp_irq);
            end
            if (k >= LAT + 1) begin
                exp8 = sb.pop_front();
                vectors++;
                if (bus.dout !== exp8) begin
                    miscompares++;
                    $display("FAIL rise_stat_k%0d: got %h required %h", k, bus.dout, exp8);
                end
            end
        end
        wr(ra(R_STAT, 0), 8'h01);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL w1c_irq_lag: got %b required 1", irq);
        end
        tick();
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL w1c_irq_clear: got %b required 0", irq);
        end
        port_i[0] = 1'b0;
        for (int k = 0; k < LAT + 3; k++) tick();
        wr(ra(R_FALL, 0), 8'h01);
        for (int k = 0; k < 4; k++) tick();
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL no_event_disabled: got %b required 0", irq);
        end
    endtask

    task automatic test_set_beats_clear();
        port_i[2] = 1'b1;
        for (int k = 0; k < LAT + 2; k++) tick();
        wr(ra(R_FALL, 0), 8'h04);
        port_i[2] = 1'b0;
        for (int k = 1; k <= LAT; k++) tick();
        bus.addr = ra(R_STAT, 0); bus.din = 8'h04; bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        tick();
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL set_beats_clear_irq: got %b required 1", irq);
        end
        sb.push_back(8'h04);
        rd(ra(R_STAT, 0));
        exp8 = sb.pop_front();
        vectors++;
        if (bus.dout !== exp8) begin
            miscompares++;
            $display("FAIL set_beats_clear_stat: got %h required %h", bus.dout, exp8);
        end
        wr(ra(R_STAT, 0), 8'h04);
        tick();
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL later_w1c: got %b required 0", irq);
        end
    endtask

`ifdef GPIO_DEBOUNCE_EN
    task automatic test_debounce();
        wr(ra(R_RISE, 0), 8'h20);
        port_i[5] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        port_i[5] = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        sb.push_back(8'h00);
        rd(ra(R_IN, 0));
        exp8 = sb.pop_front();
        vectors++;
        if (bus.dout !== exp8 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_rejected: got in=%h irq=%b required in=%h irq=0", bus.dout, irq, exp8);
        end
        port_i[5] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            if (k >= 6) begin
                bus.addr = ra(R_IN, 0); bus.rd_en = 1'b1;
                sb.push_back((k == 7) ? 8'h20 : 8'h00);
            end
            tick();
            bus.rd_en = 1'b0;
            if (k == 6) port_i[5] = 1'b0;
            if (k >= 6) begin
                exp8 = sb.pop_front();
                vectors++;
                if (bus.dout !== exp8) begin
                    miscompares++;
                    $display("FAIL debounce_pulse_k%0d: got %h required %h", k, bus.dout, exp8);
                end
            end
        end
    endtask
`endif

    initial begin
        bus.addr = '0; bus.din = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        #1;
        test_reset();
        test_byte_lanes();
        test_outset_clr();
        test_rw_priority();
        test_in_latency();
        test_rise_irq();
        test_set_beats_clear();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
